// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter that gives four requesters turns at writing one shared
// external D latch. It sequences each write as setup, open, hold and ack so
// the latch sees stable data on both sides of its enable pulse.
module latch_write_arbiter #(
  parameter int WIDTH       = 8,
  parameter int OPEN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] data_in,
  output logic [3:0]         grant,
  output logic [3:0]         ack,
  output logic               busy,
  output logic               latch_en,
  output logic [WIDTH-1:0]   latch_d
);

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, HOLD, ACK} state_t;

  localparam logic [3:0] NOPEN = 4'(OPEN_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic [1:0] ptr;
  logic [1:0] win;
  logic [1:0] pick;
  logic [1:0] idx;
  logic       found;

  // Round-robin search: first asserted req at or after ptr, wrapping mod 4.
  always_comb begin
    pick  = ptr;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Transaction sequencer; every output is a flop written alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      latch_en <= 1'b0;
      latch_d  <= '0;
      cnt      <= '0;
      ptr      <= '0;
      win      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= 4'b0001 << pick;
            latch_d <= data_in[pick*WIDTH +: WIDTH];
            win     <= pick;
            busy    <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          latch_en <= 1'b1;
          cnt      <= 4'd1;
          state    <= OPEN;
        end
        OPEN: begin
          // cnt tracks how many enable cycles have been issued; once the
          // pulse is done the block stays one closing cycle in OPEN with the
          // enable low before moving to the data-hold cycle.
          if (latch_en) begin
            if (cnt == NOPEN) latch_en <= 1'b0;
            else              cnt      <= cnt + 4'd1;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          ack   <= grant;
          ptr   <= win + 2'd1;
          state <= ACK;
        end
        ACK: begin
          grant <= '0;
          ack   <= '0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Bench for latch_write_arbiter: three instances (OPEN_CYCLES 2, 1, 15) share
// stimulus; each has a protocol monitor, and the OPEN_CYCLES=2 instance also
// has a grant/data scoreboard fed by the stimulus process.
module tb_latch_write_arbiter;
  localparam int W = 8;

  typedef struct packed {
    logic [3:0]   g;
    logic [W-1:0] d;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           rst_s = 1'b0;
  logic [3:0]     req = '0;
  logic [4*W-1:0] data_in = '0;

  logic [3:0]   grant_w [3];
  logic [3:0]   ack_w   [3];
  logic         busy_w  [3];
  logic         le_w    [3];
  logic [W-1:0] ld_w    [3];

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];
  int   rd = 0;
  logic sb_trk = 1'b0;

  always #5 clk = ~clk;

  // rst as the DUTs sampled it on the last rising edge
  always @(posedge clk) rst_s <= rst;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic oh0(input logic [3:0] v);
    return (v & (v - 4'd1)) == 4'd0;
  endfunction

  for (genvar i = 0; i < 3; i++) begin : g_mon
    localparam int N = (i == 0) ? 2 : (i == 1) ? 1 : 15;
    int           acnt = 0;
    int           cyc  = 0;
    int           le_n = 0;
    logic         trk  = 1'b0;
    logic         post = 1'b0;
    logic [3:0]   g_rec = '0;
    logic [W-1:0] d_rec = '0;

    latch_write_arbiter #(.WIDTH(W), .OPEN_CYCLES(N)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .data_in  (data_in),
      .grant    (grant_w[i]),
      .ack      (ack_w[i]),
      .busy     (busy_w[i]),
      .latch_en (le_w[i]),
      .latch_d  (ld_w[i])
    );

    // protocol monitor: invariants every cycle, timing per transaction
    always @(negedge clk) begin
      if (rst_s) begin
        chk("reset_outs", {grant_w[i], ack_w[i], busy_w[i], le_w[i], ld_w[i]}, '0);
        trk  = 1'b0;
        post = 1'b0;
      end else begin
        chk("invariant", oh0(grant_w[i]) && oh0(ack_w[i]) &&
            (!le_w[i] || (trk && ack_w[i] == 4'd0)) && (ack_w[i] == 4'd0 || trk), 1);
        if (post) begin
          chk("idle_after_ack", {busy_w[i], grant_w[i]}, 0);
          post = 1'b0;
        end
        if (trk) begin
          cyc++;
          chk("grant_data_stable", {grant_w[i], ld_w[i]}, {g_rec, d_rec});
          if (le_w[i]) begin
            if (le_n == 0) chk("le_rise_cycle", cyc, 1);
            le_n++;
          end
          if (ack_w[i] != 4'd0) begin
            chk("ack_eq_grant", ack_w[i], g_rec);
            chk("ack_latency", cyc, N + 3);
            chk("le_high_count", le_n, N);
            trk  = 1'b0;
            post = 1'b1;
            acnt++;
          end
        end else if (grant_w[i] != 4'd0) begin
          chk("setup_le_low", {le_w[i], busy_w[i]}, 2'b01);
          trk   = 1'b1;
          g_rec = grant_w[i];
          d_rec = ld_w[i];
          cyc   = 0;
          le_n  = 0;
        end
      end
    end
  end

  // scoreboard on the OPEN_CYCLES=2 instance: peek at grant, pop at ack
  always @(negedge clk) begin
    if (rst_s) begin
      if (sb_trk) rd++;
      sb_trk = 1'b0;
    end else if (!sb_trk && grant_w[0] != 4'd0) begin
      sb_trk = 1'b1;
      if (rd < sb.size()) begin
        chk("sb_grant", grant_w[0], sb[rd].g);
        chk("sb_latch_d", ld_w[0], sb[rd].d);
      end else begin
        chk("sb_unexpected_grant", grant_w[0], 0);
      end
    end else if (sb_trk && ack_w[0] != 4'd0) begin
      if (rd < sb.size()) begin
        chk("sb_ack", ack_w[0], sb[rd].g);
        chk("sb_ack_latch_d", ld_w[0], sb[rd].d);
      end
      rd++;
      sb_trk = 1'b0;
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int target);
    for (int k = 0; k < 400 && g_mon[0].acnt < target; k++) cyc_n(1);
    chk("wait_ack", g_mon[0].acnt, target);
  endtask

  initial begin
    cyc_n(2);
    rst = 1'b0;
    cyc_n(1);

    // single request, slot 0 = A5
    data_in = {8'h44, 8'h33, 8'h22, 8'hA5};
    sb.push_back(exp_t'{g: 4'b0001, d: 8'hA5});
    req = 4'b0001;
    cyc_n(1);
    req = 4'b0000;
    wait_ack(1);

    // winner drops req and zeroes its data during OPEN; snapshot must hold
    data_in[15:8] = 8'h3C;
    sb.push_back(exp_t'{g: 4'b0010, d: 8'h3C});
    req = 4'b0010;
    cyc_n(1);
    req = 4'b0000;
    cyc_n(1);
    data_in[15:8] = 8'h00;
    wait_ack(2);

    // ptr now 2: requesters 1 and 3 -> 3 first, then 1
    data_in = {8'hD3, 8'h77, 8'hD1, 8'h66};
    sb.push_back(exp_t'{g: 4'b1000, d: 8'hD3});
    sb.push_back(exp_t'{g: 4'b0010, d: 8'hD1});
    req = 4'b1010;
    wait_ack(4);
    req = 4'b0000;

    // reset during the second OPEN cycle; transaction must be dropped
    data_in[23:16] = 8'h5A;
    sb.push_back(exp_t'{g: 4'b0100, d: 8'h5A});
    req = 4'b0100;
    cyc_n(1);
    req = 4'b0000;
    cyc_n(2);
    rst = 1'b1;
    cyc_n(1);

    // all four requesting from reset: 0,1,2,3,0
    rst = 1'b0;
    data_in = {8'h04, 8'h03, 8'h02, 8'h01};
    sb.push_back(exp_t'{g: 4'b0001, d: 8'h01});
    sb.push_back(exp_t'{g: 4'b0010, d: 8'h02});
    sb.push_back(exp_t'{g: 4'b0100, d: 8'h03});
    sb.push_back(exp_t'{g: 4'b1000, d: 8'h04});
    sb.push_back(exp_t'{g: 4'b0001, d: 8'h01});
    req = 4'b1111;
    wait_ack(9);
    req = 4'b0000;

    cyc_n(60);
    chk("sb_left", sb.size() - rd, 0);
    chk("n1_acks_seen", g_mon[1].acnt != 0, 1);
    chk("n15_acks_seen", g_mon[2].acnt != 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/latch_write_arbiter.md
LATCH_WRITE_ARBITER -- requirements
Module: latch_write_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width of the shared latch.
REQ-002 SHALL have parameter OPEN_CYCLES, default 2: cycles latch_en is held high; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port req  input  4  per-requester write request; bit i belongs to requester i.
REQ-006 SHALL have port data_in  input  4*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port grant  output  4  one-hot owner of the current transaction; all-zero when idle.
REQ-008 SHALL have port ack  output  4  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL have port latch_en  output  1  enable (clk pin) of the shared external D latch.
REQ-011 SHALL have port latch_d  output  WIDTH  data (d pin) of the shared external D latch.

Function
REQ-012 SHALL implement states IDLE, SETUP, OPEN, HOLD and ACK; all outputs SHALL be registered.
REQ-013 In IDLE with req != 0: SHALL pick the winner round-robin, starting the search at ptr and ascending mod 4.
REQ-013 (cont.) On the same edge: SHALL load grant (one-hot winner), snapshot the winner's data_in slice into latch_d, and go to SETUP.
REQ-014 In IDLE with req == 0: SHALL stay in IDLE with grant, ack and latch_en all 0.
REQ-015 SETUP SHALL last 1 cycle with latch_en=0 (data setup), then go to OPEN.
REQ-016 OPEN SHALL hold latch_en=1 for exactly OPEN_CYCLES cycles, counted by a 4-bit counter, then go to HOLD.
REQ-017 HOLD SHALL last 1 cycle with latch_en=0 and latch_d unchanged (data hold), then go to ACK.
REQ-018 ACK SHALL last 1 cycle: ack equals grant and ptr = (winner+1) mod 4.
REQ-018 (cont.) On the next edge: SHALL clear grant and ack and return to IDLE.
REQ-019 latch_d SHALL remain constant from SETUP through ACK, regardless of data_in changes.
REQ-020 Latency, req first sampled in IDLE at edge E0, OPEN_CYCLES=N:
- grant valid after E0;
- latch_en high after E1 through E(1+N);
- ack high for one cycle after E(N+3);
- busy low after E(N+4).
REQ-021 req deasserted mid-transaction SHALL NOT abort the transaction: it completes with ack.
REQ-022 req changes outside IDLE SHALL be ignored; arbitration happens only in IDLE.
REQ-023 Back-to-back: the earliest next grant is the edge after the return to IDLE.
REQ-023 (cont.) This gives a 1-cycle IDLE gap with busy=0 between transactions.
REQ-024 latch_en SHALL never be high in IDLE, SETUP, HOLD or ACK.
REQ-025 grant and ack SHALL each be one-hot or zero at all times.

Reset
REQ-026 On rst=1 at a clock edge, the block SHALL enter IDLE regardless of current state, including mid-OPEN.
REQ-026 (cont.) Values after that edge: grant=0, ack=0, busy=0, latch_en=0, latch_d=0, counter=0, ptr=0.
REQ-027 rst SHALL take priority over all other inputs.
REQ-028 No ack SHALL be issued for a transaction interrupted by reset.

Verification
REQ-029 Single request, WIDTH=8, N=2: req=0001, data slot0=8'hA5 ->
- grant=0001 after E0;
- latch_d=8'hA5 after E0;
- latch_en high exactly 2 cycles;
- ack=0001 one cycle after E5;
- busy low after E6.
REQ-030 All four requesting continuously from reset: grant order SHALL be 0001, 0010, 0100, 1000, 0001, one ack per transaction.
REQ-031 Requesters 1 and 3 requesting, ptr=2 -> requester 3 is granted first, then requester 1.
REQ-032 Winner changes data_in to 8'h00 and drops req during OPEN -> latch_d stays at the snapshot value and ack is still issued.
REQ-033 rst asserted during the 2nd OPEN cycle ->
- latch_en=0 and all outputs zero after that edge;
- no ack issued;
- next grant after reset starts the search from requester 0.
REQ-034 Parameter sweep with OPEN_CYCLES=1 and 15 -> latch_en high count equals OPEN_CYCLES.
REQ-034 (cont.) The checker SHALL confirm REQ-024 and REQ-025 on every cycle.
